// File: rtl/adc_spi_sequencer.sv
// Round-robin ADC channel scanner driving an SPI master through ENA/FIN handshake.
// Optional XFER watchdog enabled by defining SEQ_TIMEOUT_EN.
module adc_spi_sequencer #(
    parameter int unsigned NUM_CH       = 4,
    parameter logic [15:0] CMD_TEMPLATE = 16'h8000,
    parameter int unsigned CH_SHIFT     = 10,
    parameter int unsigned GAP_CYC      = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  ch_mask_i,
    input  logic        fin_i,
    input  logic [15:0] data_miso_i,
    output logic        ena_o,
    output logic [15:0] data_mosi_o,
    output logic [15:0] sample_o,
    output logic [2:0]  sample_ch_o,
    output logic        sample_valid_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

    localparam int unsigned CntMax = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam logic [7:0]  ChEn   = 8'((1 << NUM_CH) - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StXfer, StLatch, StCapture, StGap} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [15:0]     mosi_q, mosi_d;
    logic [15:0]     sample_q, sample_d;
    logic [2:0]      sch_q, sch_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [7:0]      mask_eff;
    logic            any_en;
    logic [2:0]      nxt_ch;
    logic [2:0]      cand;
    logic            found;

    assign mask_eff = ch_mask_i & ChEn;
    assign any_en   = |mask_eff;

    // First enabled channel strictly after ptr_q, wrapping at NUM_CH.
    always_comb begin
        nxt_ch = ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = 3'((32'(ptr_q) + i) % NUM_CH);
            if (!found && mask_eff[cand]) begin
                nxt_ch = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        mosi_d   = mosi_q;
        sample_d = sample_q;
        sch_d    = sch_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && any_en) begin
                    state_d = StLoad;
                    ptr_d   = nxt_ch;
                    mosi_d  = CMD_TEMPLATE | (16'(nxt_ch) << CH_SHIFT);
                end
            end
            StLoad: begin
                state_d = StXfer;
                cnt_d   = '0;
            end
            StXfer: begin
                if (fin_i) begin
                    state_d = StLatch;
                    cnt_d   = '0;
`ifdef SEQ_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StLatch: begin
                if (cnt_q == CW'(1)) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                state_d  = StGap;
                cnt_d    = '0;
                sample_d = data_miso_i;
                sch_d    = ptr_q;
                valid_d  = 1'b1;
            end
            StGap: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (start_i && any_en) begin
                        state_d = StLoad;
                        ptr_d   = nxt_ch;
                        mosi_d  = CMD_TEMPLATE | (16'(nxt_ch) << CH_SHIFT);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer resets to the last channel so the first search begins at channel 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= 3'(NUM_CH - 1);
            mosi_q   <= '0;
            sample_q <= '0;
            sch_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            mosi_q   <= mosi_d;
            sample_q <= sample_d;
            sch_q    <= sch_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ena_o          = (state_q == StXfer) || (state_q == StLatch);
    assign busy_o         = (state_q != StIdle);
    assign data_mosi_o    = mosi_q;
    assign sample_o       = sample_q;
    assign sample_ch_o    = sch_q;
    assign sample_valid_o = valid_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err_o  = err_q;
`else
    assign timeout_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed self-checking bench for adc_spi_sequencer with a simple SPI master model.
module tb_adc_spi_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mask;
    logic        fin;
    logic [15:0] miso;
    logic        ena_o;
    logic [15:0] data_mosi_o;
    logic [15:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic        sample_valid_o;
    logic        busy_o;
    logic        timeout_err_o;

    int errors = 0;
    int checks = 0;

    bit spi_on = 1'b1;
    int xcnt = 0;
    bit fin_done = 1'b0;

    int          s_ch[$];
    logic [15:0] s_dat[$];
    logic [15:0] mosi_log[$];
    int          low_log[$];
    int          low_cnt = 0;
    logic        ena_prev = 1'b0;

    adc_spi_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .ch_mask_i      (mask),
        .fin_i          (fin),
        .data_miso_i    (miso),
        .ena_o          (ena_o),
        .data_mosi_o    (data_mosi_o),
        .sample_o       (sample_o),
        .sample_ch_o    (sample_ch_o),
        .sample_valid_o (sample_valid_o),
        .busy_o         (busy_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    // SPI master model: FIN one cycle on the 3rd ENA-high cycle, returns 0x0100 + channel.
    initial begin
        fin  = 1'b0;
        miso = 16'h0000;
        forever begin
            @(negedge clk);
            if (ena_o && spi_on && !fin_done) begin
                xcnt++;
                if (xcnt == 3) begin
                    fin      = 1'b1;
                    miso     = 16'h0100 + {13'd0, data_mosi_o[12:10]};
                    fin_done = 1'b1;
                end
            end else begin
                fin = 1'b0;
                if (!ena_o) begin
                    xcnt     = 0;
                    fin_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: sample strobes, command at each ENA rise, ENA-low run lengths.
    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid_o) begin
                s_ch.push_back(int'(sample_ch_o));
                s_dat.push_back(sample_o);
            end
            if (ena_o && !ena_prev) begin
                mosi_log.push_back(data_mosi_o);
                low_log.push_back(low_cnt);
                low_cnt = 0;
            end else if (!ena_o) begin
                low_cnt++;
            end
            ena_prev = ena_o;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        mask  = 8'h00;
        repeat (3) @(negedge clk);
        s_ch.delete();
        s_dat.delete();
        mosi_log.delete();
        low_log.delete();
        low_cnt = 0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mask  = 8'h00;
        repeat (2) @(negedge clk);
        checks += 7;
        if (ena_o !== 1'b0) begin errors++; $display("FAIL reset_ena got=%b exp=0", ena_o); end
        if (data_mosi_o !== 16'h0) begin errors++; $display("FAIL reset_mosi got=%h exp=0000", data_mosi_o); end
        if (sample_o !== 16'h0) begin errors++; $display("FAIL reset_sample got=%h exp=0000", sample_o); end
        if (sample_ch_o !== 3'd0) begin errors++; $display("FAIL reset_sample_ch got=%0d exp=0", sample_ch_o); end
        if (sample_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL reset_terr got=%b exp=0", timeout_err_o); end
        rst = 1'b0;
    endtask

    task automatic test_scan_all();
        do_reset();
        mask  = 8'h0F;
        start = 1'b1;
        for (int i = 0; i < 1000 && s_ch.size() < 5; i++) @(negedge clk);
        start = 1'b0;
        checks++;
        if (s_ch.size() < 5) begin errors++; $display("FAIL scan_timeout got=%0d samples exp=5", s_ch.size()); end
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (s_ch[i] !== (i % 4)) begin
                errors++; $display("FAIL scan_ch[%0d] got=%0d exp=%0d", i, s_ch[i], i % 4);
            end
            if (s_dat[i] !== 16'(16'h0100 + i % 4)) begin
                errors++; $display("FAIL scan_data[%0d] got=%h exp=%h", i, s_dat[i], 16'h0100 + i % 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mosi_log[i] !== (16'h8000 | 16'(i << 10))) begin
                errors++; $display("FAIL scan_mosi[%0d] got=%h exp=%h", i, mosi_log[i], 16'h8000 | 16'(i << 10));
            end
        end
    endtask

    task automatic test_mask_sparse();
        do_reset();
        mask  = 8'h05;
        start = 1'b1;
        for (int i = 0; i < 1000 && s_ch.size() < 4; i++) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_ch[i] !== (i % 2) * 2) begin
                errors++; $display("FAIL sparse_ch[%0d] got=%0d exp=%0d", i, s_ch[i], (i % 2) * 2);
            end
        end
        // Low time between pulses: CAPTURE (1) + GAP (4) + LOAD (1).
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (low_log[i] !== 6) begin
                errors++; $display("FAIL sparse_gap[%0d] got=%0d exp=6", i, low_log[i]);
            end
        end
    endtask

    task automatic test_stop_mid();
        int  gap_n;
        bit  seen;
        bit  hit;
        do_reset();
        mask  = 8'h0F;
        start = 1'b1;
        hit   = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            hit = ena_o && (data_mosi_o == 16'h8400);
        end
        start = 1'b0;
        gap_n = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && busy_o; i++) begin
            @(negedge clk);
            if (sample_valid_o) seen = 1'b1;
            if (seen && busy_o) gap_n++;
        end
        checks += 5;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy_o); end
        if (ena_o !== 1'b0) begin errors++; $display("FAIL stop_ena got=%b exp=0", ena_o); end
        if (s_ch.size() !== 2) begin errors++; $display("FAIL stop_count got=%0d exp=2", s_ch.size()); end
        if (s_ch[1] !== 1) begin errors++; $display("FAIL stop_ch got=%0d exp=1", s_ch[1]); end
        if (gap_n !== 4) begin errors++; $display("FAIL stop_gap got=%0d exp=4", gap_n); end
    endtask

    task automatic test_mask_zero();
        int bad;
        do_reset();
        mask  = 8'h00;
        start = 1'b1;
        bad   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            fin = 1'b1;
            if (ena_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL zero_mask_idle got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_rst_latch();
        bit hit;
        do_reset();
        mask  = 8'h0F;
        start = 1'b1;
        hit   = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk);
            hit = fin && (data_mosi_o == 16'h8400);
        end
        #2;
        checks += 4;
        if (ena_o !== 1'b1) begin errors++; $display("FAIL rst_pre_latch_ena got=%b exp=1", ena_o); end
        rst = 1'b1;
        #1;
        if (ena_o !== 1'b0) begin errors++; $display("FAIL rst_async_ena got=%b exp=0", ena_o); end
        s_ch.delete();
        s_dat.delete();
        repeat (3) @(negedge clk);
        if (s_ch.size() !== 0) begin errors++; $display("FAIL rst_no_valid got=%0d exp=0", s_ch.size()); end
        rst = 1'b0;
        for (int i = 0; i < 500 && s_ch.size() < 1; i++) @(negedge clk);
        start = 1'b0;
        if (s_ch[0] !== 0) begin errors++; $display("FAIL rst_restart_ch got=%0d exp=0", s_ch[0]); end
    endtask

    task automatic test_timeout();
        int n;
        spi_on = 1'b0;
        do_reset();
        mask  = 8'h03;
        start = 1'b1;
        for (int i = 0; i < 100 && !ena_o; i++) @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 200 && ena_o; i++) begin
            @(negedge clk);
            if (ena_o) n++;
        end
        n++;
        checks += 5;
        if (n !== 64) begin errors++; $display("FAIL to_xfer_len got=%0d exp=64", n); end
        if (timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_err_set got=%b exp=1", timeout_err_o); end
        if (s_ch.size() !== 0) begin errors++; $display("FAIL to_no_valid got=%0d exp=0", s_ch.size()); end
        for (int i = 0; i < 100 && !ena_o; i++) @(negedge clk);
        if (data_mosi_o !== 16'h8400) begin errors++; $display("FAIL to_next_ch got=%h exp=8400", data_mosi_o); end
        if (timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err_o); end
`else
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ena_o) n++;
        end
        checks += 2;
        if (n !== 200) begin errors++; $display("FAIL wait_fin_ena got=%0d exp=200", n); end
        if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL wait_fin_terr got=%b exp=0", timeout_err_o); end
`endif
        start  = 1'b0;
        spi_on = 1'b1;
        do_reset();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mask  = 8'h00;
        test_reset();
        test_scan_all();
        test_mask_sparse();
        test_stop_mid();
        test_mask_zero();
        fin = 1'b0;
        test_rst_latch();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_sequencer.md
ADC_SPI_SEQUENCER -- requirements
Module: adc_spi_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of ADC channels scanned (1..8).
REQ-002 Parameter CMD_TEMPLATE, default 16'h8000, fixed command bits sent each transaction.
REQ-003 Parameter CH_SHIFT, default 10, bit position of the 3-bit channel field in the command word.
REQ-004 Parameter GAP_CYC, default 4, ENA-low cycles between transactions (min 1).
REQ-005 Parameter TIMEOUT_CYC, default 64, max XFER cycles before abort (SEQ_TIMEOUT_EN only).
REQ-006 CLK  input  1  system clock; also drives the SPI master's SPI_CLK.
REQ-007 RST  input  1  asynchronous, active-high reset.
REQ-008 START  input  1  level; 1 = run continuous scan, 0 = stop after current transaction.
REQ-009 CH_MASK  input  8  channel enables; bit i enables channel i; bits >= NUM_CH ignored.
REQ-010 FIN  input  1  transaction-done flag from SPI master.
REQ-011 DATA_MISO  input  16  received word from SPI master.
REQ-012 ENA  output  1  SPI master enable (1 = chip select active).
REQ-013 DATA_MOSI  output  16  command word to SPI master.
REQ-014 SAMPLE  output  16  last captured conversion result.
REQ-015 SAMPLE_CH  output  3  channel index of SAMPLE.
REQ-016 SAMPLE_VALID  output  1  one-cycle strobe, SAMPLE/SAMPLE_CH updated.
REQ-017 BUSY  output  1  1 in any state other than IDLE.
REQ-018 TIMEOUT_ERR  output  1  sticky watchdog error flag.

Function
REQ-019 States SHALL be IDLE, LOAD, XFER, LATCH, CAPTURE, GAP.
REQ-020 IDLE -> LOAD when START=1 and masked CH_MASK nonzero; otherwise remain IDLE, ENA=0.
REQ-021 Channel selection SHALL be round-robin: in IDLE->LOAD or GAP->LOAD, pick first enabled channel strictly after the previous one, wrapping NUM_CH-1 -> 0; first pick after reset starts search at channel 0.
REQ-022 LOAD SHALL last 1 cycle with ENA=0 and DATA_MOSI = CMD_TEMPLATE OR (ch << CH_SHIFT); DATA_MOSI held constant until next LOAD.
REQ-023 XFER: ENA=1; leave to LATCH on first cycle FIN=1 is sampled.
REQ-024 LATCH: ENA=1 for exactly 2 cycles so the master's hold register settles, then CAPTURE.
REQ-025 CAPTURE: ENA=0 for 1 cycle; DATA_MISO registered into SAMPLE, channel into SAMPLE_CH, SAMPLE_VALID=1 in the following cycle only.
REQ-026 GAP: ENA=0 for GAP_CYC cycles; then LOAD if START=1 and mask nonzero, else IDLE.
REQ-027 START deasserted or CH_MASK changed mid-transaction SHALL NOT truncate it; mask sampled only at channel selection.
REQ-028 Single enabled channel SHALL be resampled every transaction.
REQ-029 FIN=1 observed in LOAD, GAP or IDLE SHALL be ignored.
REQ-030 BUSY=0 only in IDLE.

Reset
REQ-031 RST=1 SHALL immediately force IDLE, ENA=0, DATA_MOSI=0, SAMPLE=0, SAMPLE_CH=0, SAMPLE_VALID=0, TIMEOUT_ERR=0, round-robin pointer to "before channel 0", counters 0.
REQ-032 RST asserted mid-transaction SHALL drop ENA asynchronously; no SAMPLE_VALID for the aborted channel.

Configuration
REQ-033 Macro SEQ_TIMEOUT_EN defined: XFER counts cycles; at TIMEOUT_CYC without FIN, go to GAP with ENA=0, set TIMEOUT_ERR (sticky until RST), no SAMPLE_VALID, next channel per round-robin.
REQ-034 Macro SEQ_TIMEOUT_EN undefined: XFER waits indefinitely for FIN; TIMEOUT_ERR tied to 0; no counter logic.

Verification
REQ-035 Reset then START=1, CH_MASK=8'h0F, SPI model returns 16'h0100+ch -> SAMPLE_CH sequence 0,1,2,3,0; SAMPLE matches; DATA_MOSI=16'h8000,16'h8400,16'h8800,16'h8C00.
REQ-036 CH_MASK=8'h05 -> channels 0,2,0,2; GAP exactly 4 ENA-low cycles plus 1 LOAD cycle between ENA pulses.
REQ-037 START 1->0 during XFER of channel 1 -> transaction completes, one SAMPLE_VALID with SAMPLE_CH=1, GAP, then IDLE, BUSY=0.
REQ-038 CH_MASK=8'h00, START=1 -> stays IDLE, ENA=0, BUSY=0 for 100 cycles.
REQ-039 RST pulse during LATCH -> ENA=0 same cycle, no SAMPLE_VALID, next scan starts at channel 0.
REQ-040 SEQ_TIMEOUT_EN, FIN held 0 -> ENA falls after 64 XFER cycles, TIMEOUT_ERR=1 and stays 1, scan moves to next channel.
